max7219_frame_driver: RTL

//   Parametrised MAX7219 chain driver: holds an 8-row frame buffer per cascaded device, runs the power-up

---
 rtl/max7219_pkg.sv | 50 +++++
 rtl/max7219_spi_tx.sv | 132 +++++++++++++
 rtl/max7219_frame_driver.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 chain driver: register addresses,
// sequencer/transmitter state encodings and packet word helpers.
// Contents:
//   REG_*          MAX7219 register addresses
//   seq_state_e    frame sequencer states
//   tx_state_e     SPI transmitter states
//   pack_word()    builds a 16-bit {4'h0, addr, data} word
//   init_word()    word for power-up init packet idx (0..12)
package max7219_pkg;

  localparam logic [3:0] REG_DIGIT0    = 4'h1;
  localparam logic [3:0] REG_DECODE    = 4'h9;
  localparam logic [3:0] REG_INTENSITY = 4'hA;
  localparam logic [3:0] REG_SCANLIM   = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
  localparam logic [3:0] REG_TEST      = 4'hF;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_INTEN,
    ST_FRAME,
    ST_DONE
  } seq_state_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LOW,
    TX_HIGH,
    TX_TAIL,
    TX_GAP
  } tx_state_e;

  function automatic logic [15:0] pack_word(input logic [3:0] addr, input logic [7:0] data);
    return {4'h0, addr, data};
  endfunction

  // Init packets 0..4 configure the chip, 5..12 blank digit rows 1..8.
  function automatic logic [15:0] init_word(input logic [3:0] idx, input logic [3:0] inten);
    case (idx)
      4'd0:    return pack_word(REG_TEST, 8'h00);
      4'd1:    return pack_word(REG_SHUTDOWN, 8'h01);
      4'd2:    return pack_word(REG_SCANLIM, 8'h07);
      4'd3:    return pack_word(REG_DECODE, 8'h00);
      4'd4:    return pack_word(REG_INTENSITY, {4'h0, inten});
      default: return pack_word(idx - 4'd4, 8'h00);
    endcase
  endfunction

endpackage

// File: rtl/max7219_spi_tx.sv
// One-packet 3-wire SPI shifter for a MAX7219 chain.
// Ports:
//   clk_i, rst_ni       clock, synchronous active-low reset
//   start_i, word_i     load and send word_i (accepted only while ready_o)
//   ready_o             idle and CS-high gap elapsed
//   done_o              1-cycle pulse together with the CS rise
//   cs_o, sclk_o, din_o chain pins (CS active-low, CLK idle low, MSB first)
module max7219_spi_tx
  import max7219_pkg::*;
#(
  parameter int unsigned CLK_DIV = 500,
  parameter int unsigned WIDTH   = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] word_i,
  output logic             ready_o,
  output logic             done_o,
  output logic             cs_o,
  output logic             sclk_o,
  output logic             din_o
);

  localparam int unsigned DW = $clog2(2 * CLK_DIV);
  localparam int unsigned BW = $clog2(WIDTH);

  tx_state_e        state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             cs_q, cs_d, sclk_q, sclk_d, din_q, din_d;
  logic             ready_q, ready_d, done_q, done_d;
  logic             half_end_c, gap_end_c;

  assign half_end_c = (div_q == DW'(CLK_DIV - 1));
  assign gap_end_c  = (div_q == DW'(2 * CLK_DIV - 1));

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= TX_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      din_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      din_q   <= din_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // Bit timing: CLK low half (data setup), CLK high half, tail, CS-high gap
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    unique case (state_q)
      TX_IDLE: begin
        if (start_i) begin
          state_d = TX_LOW;
          sh_d    = word_i;
          bit_d   = BW'(WIDTH - 1);
          div_d   = '0;
        end
      end
      TX_LOW: begin
        div_d = div_q + 1'b1;
        if (half_end_c) begin
          div_d   = '0;
          state_d = TX_HIGH;
        end
      end
      TX_HIGH: begin
        div_d = div_q + 1'b1;
        if (half_end_c) begin
          div_d = '0;
          if (bit_q == '0) begin
            state_d = TX_TAIL;
          end else begin
            state_d = TX_LOW;
            bit_d   = bit_q - 1'b1;
            sh_d    = sh_q << 1;
          end
        end
      end
      TX_TAIL: begin
        div_d = div_q + 1'b1;
        if (half_end_c) begin
          div_d   = '0;
          state_d = TX_GAP;
        end
      end
      TX_GAP: begin
        div_d = div_q + 1'b1;
        if (gap_end_c) begin
          div_d   = '0;
          state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Pin values follow the upcoming state so they are registered glitch-free
  always_comb begin
    cs_d    = !(state_d inside {TX_LOW, TX_HIGH, TX_TAIL});
    sclk_d  = (state_d == TX_HIGH);
    din_d   = (state_d inside {TX_LOW, TX_HIGH}) ? sh_d[WIDTH-1] : 1'b0;
    ready_d = (state_d == TX_IDLE);
    done_d  = (state_q == TX_TAIL) && (state_d == TX_GAP);
  end

  assign ready_o = ready_q;
  assign done_o  = done_q;
  assign cs_o    = cs_q;
  assign sclk_o  = sclk_q;
  assign din_o   = din_q;

endmodule

// File: rtl/max7219_frame_driver.sv
// MAX7219 chain driver: frame buffer, power-up init and frame streaming.
// Ports:
//   sys_clk, _rst            clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data    row write (addr = dev*8 + row, bit7 = column 0)
//   refresh                  request a full frame
//   intensity                brightness for register 0x0A
//   busy, frame_done         status (frame_done pulses after last CS rise)
//   CS, CLK, Din             chain pins
// Build option: define MAX7219_SCROLL_EN to add the rotating scroll offset
// and its periodic auto-refresh (adds parameter SCROLL_DIV).
module max7219_frame_driver
  import max7219_pkg::*;
#(
  parameter int unsigned N_DEV   = 1,
  parameter int unsigned CLK_DIV = 500
`ifdef MAX7219_SCROLL_EN
  ,
  parameter int unsigned SCROLL_DIV = 5000000
`endif
) (
  input  logic                       sys_clk,
  input  logic                       _rst,
  input  logic                       wr_en,
  input  logic [$clog2(N_DEV*8)-1:0] wr_addr,
  input  logic [7:0]                 wr_data,
  input  logic                       refresh,
  input  logic [3:0]                 intensity,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       CS,
  output logic                       CLK,
  output logic                       Din
);

  localparam int unsigned ROWS  = N_DEV * 8;
  localparam int unsigned AW    = $clog2(ROWS);
  localparam int unsigned WIDTH = N_DEV * 16;

  seq_state_e       state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic             issued_q, issued_d;
  logic             pend_q, pend_d;
  logic [3:0]       ishadow_q, ishadow_d;
  logic             busy_q, busy_d, fdone_q, fdone_d;
  logic [7:0]       fb_q [ROWS];
  logic [ROWS-1:0]  row_vec_c, row_rot_c;
  logic [WIDTH-1:0] tx_word_c;
  logic             issue_c, pkt_end_c, req_c, scroll_req_c;
  logic             tx_ready, tx_done;

  // Frame buffer; out-of-range rows are dropped
  always_ff @(posedge sys_clk) begin
    if (!_rst) begin
      fb_q <= '{default: '0};
    end else if (wr_en && (32'(wr_addr) < ROWS)) begin
      fb_q[wr_addr] <= wr_data;
    end
  end

  // Current row across the whole chain, device 0 in the MSBs (column 0 first)
  always_comb begin
    row_vec_c = '0;
    for (int d = 0; d < int'(N_DEV); d++) begin
      row_vec_c[(int'(N_DEV) - 1 - d) * 8 +: 8] = fb_q[AW'(d * 8) + AW'(idx_q[2:0])];
    end
  end

`ifdef MAX7219_SCROLL_EN
  localparam int unsigned SW = $clog2(SCROLL_DIV);

  logic [SW-1:0] scnt_q;
  logic [AW-1:0] offset_q;

  // Free-running step timer; each step advances the offset and requests a frame
  always_ff @(posedge sys_clk) begin
    if (!_rst) begin
      scnt_q   <= '0;
      offset_q <= '0;
    end else if (scroll_req_c) begin
      scnt_q   <= '0;
      offset_q <= (offset_q == AW'(ROWS - 1)) ? '0 : offset_q + 1'b1;
    end else begin
      scnt_q <= scnt_q + 1'b1;
    end
  end

  assign scroll_req_c = (scnt_q == SW'(SCROLL_DIV - 1));
  assign row_rot_c    = (row_vec_c << offset_q) | (row_vec_c >> (ROWS - 32'(offset_q)));
`else
  assign scroll_req_c = 1'b0;
  assign row_rot_c    = row_vec_c;
`endif

  assign req_c     = refresh || scroll_req_c;
  assign issue_c   = (state_q inside {ST_INIT, ST_INTEN, ST_FRAME}) && !issued_q && tx_ready;
  assign pkt_end_c = issued_q && tx_done;

  // Sequencer state register
  always_ff @(posedge sys_clk) begin
    if (!_rst) begin
      state_q   <= ST_INIT;
      idx_q     <= '0;
      issued_q  <= 1'b0;
      pend_q    <= 1'b0;
      ishadow_q <= '0;
      busy_q    <= 1'b1;
      fdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      issued_q  <= issued_d;
      pend_q    <= pend_d;
      ishadow_q <= ishadow_d;
      busy_q    <= busy_d;
      fdone_q   <= fdone_d;
    end
  end

  // Sequencer next state: one packet in flight, advance on its CS rise
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    issued_d  = issued_q;
    pend_d    = pend_q;
    ishadow_d = ishadow_q;
    if (req_c && (state_q != ST_IDLE)) pend_d = 1'b1;
    if (issue_c) issued_d = 1'b1;
    // Shadow tracks the last intensity actually put on the wire
    if (issue_c && (((state_q == ST_INIT) && (idx_q == 4'd4)) || (state_q == ST_INTEN))) begin
      ishadow_d = intensity;
    end
    unique case (state_q)
      ST_INIT: begin
        if (pkt_end_c) begin
          issued_d = 1'b0;
          if (idx_q == 4'd12) begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_IDLE: begin
        if (req_c || pend_q) begin
          pend_d  = 1'b0;
          idx_d   = '0;
          state_d = (intensity != ishadow_q) ? ST_INTEN : ST_FRAME;
        end
      end
      ST_INTEN: begin
        if (pkt_end_c) begin
          issued_d = 1'b0;
          state_d  = ST_FRAME;
        end
      end
      ST_FRAME: begin
        if (pkt_end_c) begin
          issued_d = 1'b0;
          if (idx_q == 4'd7) begin
            idx_d   = '0;
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
  end

  // Sequencer outputs: packet word for the current step, registered status
  always_comb begin
    tx_word_c = '0;
    busy_d    = (state_d != ST_IDLE);
    fdone_d   = (state_d == ST_DONE);
    unique case (state_q)
      ST_INIT: begin
        for (int d = 0; d < int'(N_DEV); d++) tx_word_c[d * 16 +: 16] = init_word(idx_q, intensity);
      end
      ST_INTEN: begin
        for (int d = 0; d < int'(N_DEV); d++) begin
          tx_word_c[d * 16 +: 16] = pack_word(REG_INTENSITY, {4'h0, intensity});
        end
      end
      ST_FRAME: begin
        // Highest device occupies the MSBs so it is shifted out first
        for (int d = 0; d < int'(N_DEV); d++) begin
          tx_word_c[d * 16 +: 16] = pack_word(REG_DIGIT0 + idx_q,
                                              row_rot_c[(int'(N_DEV) - 1 - d) * 8 +: 8]);
        end
      end
      default: tx_word_c = '0;
    endcase
  end

  max7219_spi_tx #(
    .CLK_DIV(CLK_DIV),
    .WIDTH  (WIDTH)
  ) u_tx (
    .clk_i  (sys_clk),
    .rst_ni (_rst),
    .start_i(issue_c),
    .word_i (tx_word_c),
    .ready_o(tx_ready),
    .done_o (tx_done),
    .cs_o   (CS),
    .sclk_o (CLK),
    .din_o  (Din)
  );

  assign busy       = busy_q;
  assign frame_done = fdone_q;

endmodule
